// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer: walks addresses 0..NREGS-1 and streams each word to a valid/ready sink.
// Optional trailing checksum beat when DUMP_CHECKSUM_EN is defined.
module regfile_dump_ctrl #(
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              out_sum,
   output logic              busy,
   output logic              done
);

`ifdef DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, SEND, SUM, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] rf_addr_nx, out_addr_nx;
   logic [DATA_W-1:0] out_data_nx;
   logic              out_valid_nx, out_last_nx;
   logic              at_last, handshake;

   assign at_last   = (rf_addr == LAST_ADDR);
   assign handshake = out_valid && out_ready;

`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] acc, acc_nx;
   logic              out_sum_r, out_sum_nx;

   // Checksum is modulo 2**DATA_W: the carry out of the top bit is dropped.
   function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      return a + b;
   endfunction

   assign out_sum = out_sum_r;
`else
   assign out_sum = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rf_addr   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         acc       <= '0;
         out_sum_r <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         rf_addr   <= rf_addr_nx;
         out_valid <= out_valid_nx;
         out_data  <= out_data_nx;
         out_addr  <= out_addr_nx;
         out_last  <= out_last_nx;
`ifdef DUMP_CHECKSUM_EN
         acc       <= acc_nx;
         out_sum_r <= out_sum_nx;
`endif
      end
   end

   always_comb begin
      state_nx     = state;
      rf_addr_nx   = rf_addr;
      out_valid_nx = out_valid;
      out_data_nx  = out_data;
      out_addr_nx  = out_addr;
      out_last_nx  = out_last;
      busy         = (state != IDLE);
      done         = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc_nx       = acc;
      out_sum_nx   = out_sum_r;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_nx   = LOAD;
               rf_addr_nx = '0;
`ifdef DUMP_CHECKSUM_EN
               acc_nx     = '0;
`endif
            end
         end
         LOAD: begin
            out_data_nx  = rf_data;
            out_addr_nx  = rf_addr;
            out_valid_nx = 1'b1;
`ifdef DUMP_CHECKSUM_EN
            out_last_nx  = 1'b0;
            out_sum_nx   = 1'b0;
            acc_nx       = wrap_add(acc, rf_data);
`else
            out_last_nx  = at_last;
`endif
            state_nx     = SEND;
         end
         SEND: begin
            if (handshake) begin
               out_valid_nx = 1'b0;
               if (at_last) begin
`ifdef DUMP_CHECKSUM_EN
                  // Sum beat follows the last word with no bubble.
                  state_nx     = SUM;
                  out_valid_nx = 1'b1;
                  out_data_nx  = acc;
                  out_addr_nx  = '0;
                  out_last_nx  = 1'b1;
                  out_sum_nx   = 1'b1;
`else
                  state_nx     = DONE;
`endif
               end else begin
                  rf_addr_nx = rf_addr + 1'b1;
                  state_nx   = LOAD;
               end
            end
         end
`ifdef DUMP_CHECKSUM_EN
         SUM: begin
            if (handshake) begin
               out_valid_nx = 1'b0;
               state_nx     = DONE;
            end
         end
`endif
         DONE: begin
            done       = 1'b1;
            rf_addr_nx = '0;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: behavioural register file plus a queue-based beat model.
module tb_regfile_dump_ctrl;

`ifdef DUMP_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  a;
      logic        l;
      logic        s;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset, start, out_ready;
   logic [4:0]  rf_addr, out_addr;
   logic [31:0] rf_data, out_data;
   logic        out_valid, out_last, out_sum, busy, done;
   logic [31:0] regs [32];

   logic        start4, out_ready4;
   logic [1:0]  rf_addr4, out_addr4;
   logic [31:0] rf_data4, out_data4;
   logic        out_valid4, out_last4, out_sum4, busy4, done4;
   logic [31:0] regs4 [4];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign rf_data  = regs[rf_addr];
   assign rf_data4 = regs4[rf_addr4];

   regfile_dump_ctrl #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .out_last(out_last), .out_sum(out_sum), .busy(busy), .done(done));

   regfile_dump_ctrl #(.NREGS(4), .ADDR_W(2), .DATA_W(32)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .rf_addr(rf_addr4), .rf_data(rf_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_addr(out_addr4),
      .out_last(out_last4), .out_sum(out_sum4), .busy(busy4), .done(done4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rf_addr"},   64'(rf_addr),   64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"},  64'(out_data),  64'd0);
      chk({tag, "_out_addr"},  64'(out_addr),  64'd0);
      chk({tag, "_out_last"},  64'(out_last),  64'd0);
      chk({tag, "_out_sum"},   64'(out_sum),   64'd0);
      chk({tag, "_busy"},      64'(busy),      64'd0);
      chk({tag, "_done"},      64'(done),      64'd0);
   endtask

   // One complete dump of the 32-entry file; the expected beat list is built from regs up front.
   task automatic run_dump(input int stall_pct, input bit extra);
      beat_t       exp_q[$];
      beat_t       e;
      logic [31:0] s;
      logic [31:0] pd;
      logic [4:0]  pa;
      logic        pl, ps;
      bit          prev_stall;
      int          n_exp, n_beats, n_done, done_at;
      s = 0; prev_stall = 0; n_beats = 0; n_done = 0; done_at = 0;
      pd = 0; pa = 0; pl = 0; ps = 0;
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back('{regs[i], 5'(i), (i == 31) && !CK, 1'b0});
         s = s + regs[i];
      end
      if (CK) exp_q.push_back('{s, 5'd0, 1'b1, 1'b1});
      n_exp = exp_q.size();
      @(negedge clk);
      start = 1'b1;
      out_ready = ($urandom_range(99) >= stall_pct);
      for (int n = 1; n <= 3000 && done_at == 0; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (extra && (n_beats == 3 || n_beats == 20)) start = 1'b1;
         if (done) begin
            n_done++;
            done_at = n;
            if (extra) start = 1'b1;
         end
         chk("busy_during_dump", 64'(busy), 64'd1);
         if (n == 1) chk("no_valid_in_load", 64'(out_valid), 64'd0);
         if (n == 2) chk("first_valid_latency", 64'(out_valid), 64'd1);
         if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data",  64'(out_data),  64'(pd));
            chk("stall_addr",  64'(out_addr),  64'(pa));
            chk("stall_last",  64'(out_last),  64'(pl));
            chk("stall_sum",   64'(out_sum),   64'(ps));
         end
         out_ready = ($urandom_range(99) >= stall_pct);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 64'(n_beats), 64'(n_exp));
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 64'(out_data), 64'(e.d));
               chk("beat_addr", 64'(out_addr), 64'(e.a));
               chk("beat_last", 64'(out_last), 64'(e.l));
               chk("beat_sum",  64'(out_sum),  64'(e.s));
            end
            n_beats++;
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data; pa = out_addr; pl = out_last; ps = out_sum;
      end
      chk("done_seen", 64'(done_at != 0), 64'd1);
      if (stall_pct == 0) chk("start_to_done_cycles", 64'(done_at), 64'(2 * 32 + 1 + int'(CK)));
      chk("beat_count", 64'(n_beats), 64'(n_exp));
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (done) n_done++;
         chk("idle_after_done_busy",  64'(busy),      64'd0);
         chk("idle_after_done_valid", 64'(out_valid), 64'd0);
         @(negedge clk);
      end
      chk("done_pulse_count", 64'(n_done), 64'd1);
   endtask

   initial begin
      int    n4, done4_at;
      bit    hit7;
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; start4 = 1'b0; out_ready4 = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = 32'hA5A50000 + i;
      for (int i = 0; i < 4; i++) regs4[i] = $urandom;
      #12;
      chk_idle("reset_state");
      @(negedge clk);
      reset = 1'b0;

      // Reset in the middle of a stalled beat at address 7.
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit7 = 0;
      for (int n = 0; n < 200 && !hit7; n++) begin
         @(negedge clk);
         if (out_valid && out_addr == 5'd7) begin
            out_ready = 1'b0;
            hit7 = 1;
         end
      end
      chk("reached_addr7", 64'(hit7), 64'd1);
      @(negedge clk);
      chk("stalled_at_addr7", 64'(out_addr), 64'd7);
      #2 reset = 1'b1;
      #1 chk_idle("async_reset");
      @(negedge clk);
      chk_idle("held_reset");
      reset = 1'b0;

      // Known pattern, sink always ready.
      run_dump(0, 1'b0);

      // Random data with a 50% stalling sink.
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(50, 1'b0);

      // Stray start pulses mid-dump and in the DONE cycle.
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(30, 1'b1);

      // All-ones file: checksum wraps.
      for (int i = 0; i < 32; i++) regs[i] = 32'hFFFFFFFF;
      run_dump(0, 1'b0);

      // Four-register instance.
      @(negedge clk);
      start4 = 1'b1; out_ready4 = 1'b1;
      n4 = 0; done4_at = 0;
      for (int n = 1; n <= 100 && done4_at == 0; n++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (done4) done4_at = n;
         chk("n4_sum_never", 64'(out_sum4 && out_addr4 != 2'd0), 64'd0);
         if (out_valid4 && !out_sum4) begin
            chk("n4_addr", 64'(out_addr4), 64'(n4));
            chk("n4_data", 64'(out_data4), 64'(regs4[n4]));
            chk("n4_last", 64'(out_last4), 64'((n4 == 3) && !CK));
            chk("n4_sum",  64'(out_sum4),  64'd0);
            n4++;
         end
      end
      chk("n4_beats", 64'(n4), 64'd4);
      chk("n4_done_cycle", 64'(done4_at), 64'(2 * 4 + 1 + int'(CK)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
